// File: rtl/barrel_sched_pkg.sv
// Shared types and helpers for the rotator-sharing scheduler.
package barrel_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // Ceiling log2, minimum 1 so single-bit fields never collapse to zero width.
  function automatic int log_2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import barrel_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = log_2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt_id     = idx;
        gnt[idx]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrel_rr_sched.sv
// Shares one barrel rotator between NREQ clients: one job in flight, round-robin
// grant, watchdog on the result, response tagged with the owning requester.
module barrel_rr_sched
  import barrel_sched_pkg::*;
#(
  parameter int N       = 32,
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int ROT_W   = log_2(N),
  parameter int ID_W    = log_2(NREQ),
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ROT_W-1:0]     req_rot,
  input  logic [NREQ*N*WIDTH-1:0]   req_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_err,
  output logic [N*WIDTH-1:0]        resp_data,
  output logic                      dp_start,
  input  logic                      dp_rdy,
  output logic [ROT_W-1:0]          dp_rot,
  output logic [N*WIDTH-1:0]        dp_ip,
  output logic                      dp_op_rdy,
  input  logic                      dp_op_valid,
  input  logic [N*WIDTH-1:0]        dp_op
);

  localparam int DW     = N * WIDTH;
  localparam int WDOG_W = log_2(TIMEOUT);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [ROT_W-1:0] rot;
    logic [DW-1:0]    data;
  } job_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            err;
    logic [DW-1:0]   data;
  } resp_t;

  state_e            state;
  job_t              job_q;
  resp_t             rsp_q;
  logic [ID_W-1:0]   rr_ptr;
  logic [WDOG_W-1:0] wdog;

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [ROT_W-1:0]  sel_rot;
  logic [DW-1:0]     sel_data;
  logic [ID_W-1:0]   next_ptr;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Grant is only offered while idle and out of reset, so a job can never be
  // taken while another is still owned by the datapath or the consumer.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign sel_rot   = req_rot[int'(gnt_id)*ROT_W +: ROT_W];
  assign sel_data  = req_data[int'(gnt_id)*DW +: DW];
  assign next_ptr  = (rsp_q.id == ID_W'(NREQ-1)) ? '0 : rsp_q.id + 1'b1;

  assign dp_rot    = job_q.rot;
  assign dp_ip     = job_q.data;
  assign resp_id   = rsp_q.id;
  assign resp_err  = rsp_q.err;
  assign resp_data = rsp_q.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      wdog       <= '0;
      job_q      <= '0;
      rsp_q      <= '0;
      dp_start   <= 1'b0;
      dp_op_rdy  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            job_q.id   <= gnt_id;
            job_q.rot  <= sel_rot;
            job_q.data <= sel_data;
            dp_start   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (dp_rdy) begin
            dp_start  <= 1'b0;
            dp_op_rdy <= 1'b1;
            wdog      <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the timeout cycle still counts as a good result.
          if (dp_op_valid) begin
            rsp_q.id   <= job_q.id;
            rsp_q.err  <= 1'b0;
            rsp_q.data <= dp_op;
            dp_op_rdy  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (wdog == WDOG_W'(TIMEOUT-1)) begin
            rsp_q.id   <= job_q.id;
            rsp_q.err  <= 1'b1;
            rsp_q.data <= '0;
            dp_op_rdy  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_rr_sched.sv
// Bench for barrel_rr_sched: job-lifecycle reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_barrel_rr_sched;

  localparam int N = 32, WIDTH = 8, NREQ = 4, ROT_W = 5, ID_W = 2, TIMEOUT = 64;
  localparam int DW = N * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*ROT_W-1:0] req_rot = '0;
  logic [NREQ*DW-1:0]    req_data = '0;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_err;
  logic [DW-1:0]         resp_data;
  logic                  dp_start;
  logic                  dp_rdy;
  logic [ROT_W-1:0]      dp_rot;
  logic [DW-1:0]         dp_ip;
  logic                  dp_op_rdy;
  logic                  dp_op_valid;
  logic [DW-1:0]         dp_op;

  barrel_rr_sched #(
    .N(N), .WIDTH(WIDTH), .NREQ(NREQ), .ROT_W(ROT_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rot(req_rot), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_err(resp_err), .resp_data(resp_data),
    .dp_start(dp_start), .dp_rdy(dp_rdy), .dp_rot(dp_rot), .dp_ip(dp_ip),
    .dp_op_rdy(dp_op_rdy), .dp_op_valid(dp_op_valid), .dp_op(dp_op)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- environment knobs (written by main, read by responders)
  bit rnd = 0;
  int stall_n = 0, op_delay = 0, hold_n = 0, op_pct = 30;
  logic [DW-1:0] last_op = '0;

  // Datapath and consumer behaviour, driven just after each rising edge.
  initial begin
    int iss_cnt, wt_cnt, hold_cnt;
    iss_cnt = 0; wt_cnt = 0; hold_cnt = 0;
    dp_rdy = 0; dp_op_valid = 0; dp_op = '0; resp_ready = 1;
    forever begin
      @(posedge clk); #1;
      for (int w = 0; w < DW/32; w++) dp_op[w*32 +: 32] = $urandom;
      if (dp_start) begin
        if (rnd) dp_rdy = 1'($urandom_range(0, 1));
        else if (iss_cnt < stall_n) begin dp_rdy = 0; iss_cnt++; end
        else dp_rdy = 1;
      end else begin
        iss_cnt = 0;
        dp_rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (dp_op_rdy) begin
        if (rnd) dp_op_valid = ($urandom_range(0, 99) < op_pct);
        else     dp_op_valid = (op_delay >= 0 && wt_cnt == op_delay);
        wt_cnt++;
        if (dp_op_valid) last_op = dp_op;
      end else begin
        wt_cnt = 0;
        dp_op_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (resp_valid) begin
        if (rnd) resp_ready = ($urandom_range(0, 99) < 60);
        else if (hold_cnt < hold_n) begin resp_ready = 0; hold_cnt++; end
        else resp_ready = 1;
      end else begin
        hold_cnt = 0;
        resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // ---------------- reference model: one job lifecycle free->issue->wait->resp
  int            m_stage = 0;   // 0 free, 1 issuing, 2 awaiting result, 3 responding
  int            m_ptr = 0, m_id = 0, m_wait = 0;
  logic [ROT_W-1:0] m_rot;
  logic [DW-1:0] m_data, m_rdata;
  logic          m_err;
  bit            chk_zero = 1;

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rr;
    if (chk_zero) begin
      chk("rst_dp_start", dp_start, 0);
      chk("rst_dp_op_rdy", dp_op_rdy, 0);
      chk("rst_dp_rot", dp_rot, 0);
      chk("rst_dp_ip", dp_ip, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_data", resp_data, 0);
      chk_zero = 0;
    end
    g = -1;
    if (m_stage == 0 && !rst)
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
    exp_rr = '0;
    if (g >= 0) exp_rr[g] = 1'b1;
    chk("req_ready", req_ready, exp_rr);
    chk("dp_start", dp_start, (m_stage == 1));
    if (m_stage == 1) begin
      chk("dp_rot", dp_rot, m_rot);
      chk("dp_ip", dp_ip, m_data);
    end
    chk("dp_op_rdy", dp_op_rdy, (m_stage == 2));
    chk("resp_valid", resp_valid, (m_stage == 3));
    if (m_stage == 3) begin
      chk("resp_id", resp_id, m_id);
      chk("resp_err", resp_err, m_err);
      chk("resp_data", resp_data, m_rdata);
    end
    if (rst) begin
      m_stage = 0; m_ptr = 0; chk_zero = 1;
    end else begin
      case (m_stage)
        0: if (g >= 0) begin
             m_id = g; m_rot = req_rot[g*ROT_W +: ROT_W]; m_data = req_data[g*DW +: DW];
             m_stage = 1;
           end
        1: if (dp_rdy) begin m_stage = 2; m_wait = 0; end
        2: if (dp_op_valid) begin
             m_stage = 3; m_err = 0; m_rdata = dp_op;
           end else if (m_wait + 1 == TIMEOUT) begin
             m_stage = 3; m_err = 1; m_rdata = '0;
           end else m_wait++;
        3: if (resp_ready) begin m_ptr = (m_id + 1) % NREQ; m_stage = 0; end
        default: m_stage = 0;
      endcase
    end
  end

  // ---------------- directed helpers
  int            j_first, j_start, j_wait, j_resp;
  logic [ID_W-1:0]  j_id;
  logic          j_err;
  logic [DW-1:0] j_data, j_ip;
  logic [ROT_W-1:0] j_rot;

  task automatic run_job(input logic [NREQ-1:0] v);
    int c; bit done, g;
    req_valid = v; c = 0; done = 0;
    j_first = 0; j_start = 0; j_wait = 0; j_resp = 0;
    while (!done && c < 400) begin
      @(negedge clk); c++;
      if (dp_start) begin
        if (j_start == 0) begin j_rot = dp_rot; j_ip = dp_ip; end
        j_start++;
      end
      if (dp_op_rdy) j_wait++;
      if (resp_valid) begin
        if (j_first == 0) j_first = c;
        j_resp++;
        chk("req_ready_in_resp", req_ready, 0);
        if (resp_ready) begin done = 1; j_id = resp_id; j_err = resp_err; j_data = resp_data; end
      end
      g = |(req_valid & req_ready);
      @(posedge clk); #1;
      if (g) req_valid = '0;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL run_job_timeout: no response after %0d cycles", c);
    end
  endtask

  task automatic rst_pulse(input int n);
    rst = 1; req_valid = '0;
    repeat (n) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence
  initial begin
    logic [DW-1:0] exp0;
    int gq[$], rq[$];
    int c, ng, nr;
    bit found;

    for (int k = 0; k < NREQ; k++) begin
      for (int w = 0; w < DW/32; w++) req_data[k*DW + w*32 +: 32] = $urandom;
      req_rot[k*ROT_W +: ROT_W] = ROT_W'($urandom);
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Single job: requester 0, rot 11, element i = i, result after 3 WAIT cycles.
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(i);
    req_rot[0 +: ROT_W] = 5'd11;
    exp0 = req_data[0 +: DW];
    stall_n = 0; op_delay = 3; hold_n = 0;
    run_job(4'b0001);
    chk("single_dp_rot", j_rot, 11);
    chk("single_dp_ip", j_ip, exp0);
    chk("single_issue_cycles", j_start, 1);
    chk("single_latency", j_first, 7);
    chk("single_resp_id", j_id, 0);
    chk("single_resp_err", j_err, 0);
    chk("single_resp_data", j_data, last_op);

    // Contention: all four held valid for 8 jobs from a fresh pointer.
    rst_pulse(2);
    op_delay = 0;
    req_valid = '1; ng = 0; nr = 0; c = 0;
    while ((ng < 8 || nr < 8) && c < 2000) begin
      @(negedge clk); c++;
      if (|(req_ready & req_valid)) begin gq.push_back(oh_idx(req_ready)); ng++; end
      if (resp_valid && resp_ready) begin rq.push_back(int'(resp_id)); nr++; end
      @(posedge clk); #1;
      if (ng >= 8) req_valid = '0;
    end
    chk("contention_grants", ng, 8);
    chk("contention_resps", nr, 8);
    for (int j = 0; j < 8 && j < gq.size() && j < rq.size(); j++) begin
      chk("contention_grant_order", gq[j], j % 4);
      chk("contention_resp_id", rq[j], j % 4);
    end

    // Backpressure: consumer holds off 5 cycles.
    hold_n = 5; op_delay = 1;
    run_job(4'b0100);
    chk("bp_resp_cycles", j_resp, 6);
    chk("bp_resp_id", j_id, 2);
    chk("bp_resp_data", j_data, last_op);
    hold_n = 0;

    // Datapath stall: dp_rdy low for 4 ISSUE cycles.
    stall_n = 4;
    run_job(4'b1000);
    chk("stall_issue_cycles", j_start, 5);
    chk("stall_resp_id", j_id, 3);
    stall_n = 0;

    // Timeout, then a normal job.
    op_delay = -1;
    run_job(4'b0001);
    chk("timeout_wait_cycles", j_wait, 64);
    chk("timeout_resp_err", j_err, 1);
    chk("timeout_resp_data", j_data, 0);
    chk("timeout_resp_id", j_id, 0);
    op_delay = 2;
    run_job(4'b0010);
    chk("after_to_err", j_err, 0);
    chk("after_to_id", j_id, 1);
    chk("after_to_data", j_data, last_op);

    // Reset mid-WAIT: pointer is 2 here, so the abandoned job belongs to requester 3.
    op_delay = -1;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("pre_reset_grant", req_ready, 4'b1000);
    @(posedge clk); #1 req_valid = '0;
    c = 0; found = 0;
    while (!found && c < 20) begin
      @(negedge clk); c++;
      found = dp_op_rdy;
    end
    chk("reached_wait", found, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dp_op_rdy_lit", dp_op_rdy, 0);
    chk("rst_resp_valid_lit", resp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", resp_valid, 0);
    end
    @(posedge clk); #1 req_valid = 4'b0110;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    op_delay = 1;
    run_job('0);
    chk("post_rst_resp_id", j_id, 1);

    // Randomized traffic with occasional reset and timeout-heavy phases.
    rnd = 1;
    for (int c2 = 0; c2 < 3000; c2++) begin
      if (c2 % 250 == 0) op_pct = ((c2 / 250) % 3 == 2) ? 0 : (((c2 / 250) % 3 == 1) ? 8 : 40);
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        req_rot[k*ROT_W +: ROT_W] = ROT_W'($urandom);
        for (int w = 0; w < DW/32; w++) req_data[k*DW + w*32 +: 32] = $urandom;
      end
      rst = ($urandom_range(0, 599) == 0);
      @(posedge clk); #1;
    end
    rst = 0; rnd = 0; req_valid = '0; op_delay = 0;
    repeat (150) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
